pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage downstream of the flag tester.
- Consumes the 1-bit condition result together with decoded control bits, and updates the PC each step: sequential, jump, call or return.
- Holds a small return-address stack (RAS) for call/return.
- Drives the instruction-memory address and the fetch/halt status seen by the control unit.

Parameters:
- ADDR_W, 16, PC and jump-target width.
- RESET_VECTOR, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin execution.
- step  in  1  one-cycle pulse: commit the current instruction's PC update.
- is_jump  in  1  current instruction is a conditional/unconditional jump.
- cond_met  in  1  condition result from flag tester; qualifies is_jump.
- is_call  in  1  current instruction is a call.
- is_ret  in  1  current instruction is a return.
- halt_req  in  1  stop execution.
- jump_target  in  ADDR_W  absolute target for jump/call.
- pc  out  ADDR_W  current program counter.
- running  out  1  state == RUN.
- jump_taken  out  1  registered; high for one cycle after a step that redirected the PC.
- ras_overflow  out  1  sticky: push attempted while RAS full.
- ras_underflow  out  1  sticky: pop attempted while RAS empty.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VECTOR, state=IDLE, running=0, jump_taken=0.
  - RAS count=0, both sticky flags=0.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN on start=1.
  - RUN -> HALT on halt_req=1 or on underflow.
  - HALT is terminal until reset. start is ignored outside IDLE.
- In IDLE/HALT, step is ignored: pc and RAS hold, jump_taken=0.
- In RUN with step=1, the PC update is registered and visible the next cycle (latency 1). Priority ret > call > jump > sequential:
  - is_ret: RAS non-empty -> pc<=top, pop, jump_taken<=1. RAS empty -> pc holds, ras_underflow<=1, state<=HALT, jump_taken<=0.
  - is_call: push pc+1, pc<=jump_target, jump_taken<=1. If RAS full: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_overflow<=1.
  - is_jump & cond_met: pc<=jump_target, jump_taken<=1.
  - is_jump & !cond_met, or no op: pc<=pc+1, jump_taken<=0.
- halt_req and step in the same RUN cycle: the step commits, then the state goes to HALT.
- pc+1 and the pushed address wrap modulo 2^ADDR_W.
- RAS is a circular buffer with top pointer and count (0..RAS_DEPTH).
  - Push increments the pointer, then writes.
  - Pop reads, then decrements.
  - Pointer wraps at RAS_DEPTH.
- jump_taken is 0 on any cycle without a committed redirect.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: PC_BRANCH_COUNT_EN.
- Defined: adds output taken_count[15:0].
  - Increments on every cycle jump_taken is set.
  - Saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE=2'd0, RUN=2'd1, HALT=2'd2.
  - Op-select encoding: OP_SEQ, OP_JMP, OP_CALL, OP_RET.
  - RESET_VECTOR default.
- One natural sub-module: pc_ras_stack.
  - Parameterised RAS_DEPTH/ADDR_W.
  - push, pop, top, full, empty.
  - Asynchronous active-low reset.

Test Plan:
- Reset then start, 3 steps with no op -> pc 0,1,2,3; jump_taken stays 0.
- Step with is_jump=1, cond_met=1, target=0x0040 -> pc=0x0040 next cycle, jump_taken pulses 1. Repeat with cond_met=0 -> pc=0x0041.
- Call at pc=0x0010 to 0x0100, then ret -> pc 0x0100 then 0x0011; RAS empty after.
- 5 nested calls with RAS_DEPTH=4 -> ras_overflow=1; 4 rets return the last 4 pushed addresses in LIFO order; 5th ret -> ras_underflow=1, running=0, pc holds.
- pc=0xFFFF, sequential step -> pc=0x0000. halt_req with step -> step commits, then running=0 and further steps are ignored.
- rst_n asserted mid-RUN after two calls -> immediately pc=RESET_VECTOR, state IDLE, RAS empty, flags 0. With PC_BRANCH_COUNT_EN: 3 taken jumps -> taken_count=3.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// Shared types for the PC/branch stage: FSM states, op-select encoding and reset default.
package pc_branch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SEQ  = 2'd0,
        OP_JMP  = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } op_t;

    localparam int DEFAULT_RESET_VECTOR = 0;

    // Resolve the decoded control bits into one op; ret > call > taken jump > sequential.
    function automatic op_t decode_op(input logic is_ret, input logic is_call,
                                      input logic is_jump, input logic cond_met);
        if (is_ret)
            return OP_RET;
        else if (is_call)
            return OP_CALL;
        else if (is_jump && cond_met)
            return OP_JMP;
        else
            return OP_SEQ;
    endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack: push pre-increments the top pointer, pop reads then decrements.
module pc_ras_stack #(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  ptr_inc;
    logic [CNT_W-1:0]  count_reg;

    assign ptr_inc = ptr_reg + 1'b1;
    assign full    = (count_reg == CNT_W'(RAS_DEPTH));
    assign empty   = (count_reg == '0);
    // Combinational read so a return can redirect the PC in the same step.
    assign top     = mem[ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (push) begin
            ptr_reg <= ptr_inc;
            if (!full)
                count_reg <= count_reg + 1'b1;
        end else if (pop && !empty) begin
            ptr_reg   <= ptr_reg - 1'b1;
            count_reg <= count_reg - 1'b1;
        end
    end

    // A push into a full stack lands on the oldest entry because the pointer wraps.
    always_ff @(posedge clk) begin
        if (push)
            mem[ptr_inc] <= push_data;
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with jump/call/return resolution, RAS and IDLE/RUN/HALT control.
// Optional PC_BRANCH_COUNT_EN adds a saturating taken-redirect counter output.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic              is_jump,
    input  logic              cond_met,
    input  logic              is_call,
    input  logic              is_ret,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
`ifdef PC_BRANCH_COUNT_EN
    output logic [15:0]       taken_count,
`endif
    output logic              running,
    output logic              jump_taken,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus1;
    logic              jump_taken_reg;
    logic              jump_taken_next;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              underflow_set;
    logic              commit;
    op_t               op;

    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;

    assign op       = decode_op(is_ret, is_call, is_jump, cond_met);
    assign commit   = (state_reg == RUN) && step;
    assign pc_plus1 = pc_reg + 1'b1;
    assign ras_push = commit && (op == OP_CALL);
    assign ras_pop  = commit && (op == OP_RET) && !ras_empty;

    pc_ras_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_plus1),
        .top      (ras_top),
        .full     (ras_full),
        .empty    (ras_empty)
    );

    always_comb begin
        pc_next         = pc_reg;
        jump_taken_next = 1'b0;
        underflow_set   = 1'b0;
        if (commit) begin
            case (op)
                OP_RET: begin
                    if (ras_empty) begin
                        underflow_set = 1'b1;
                    end else begin
                        pc_next         = ras_top;
                        jump_taken_next = 1'b1;
                    end
                end
                OP_CALL, OP_JMP: begin
                    pc_next         = jump_target;
                    jump_taken_next = 1'b1;
                end
                default: pc_next = pc_plus1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pc_reg         <= ADDR_W'(RESET_VECTOR);
            jump_taken_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            pc_reg         <= pc_next;
            jump_taken_reg <= jump_taken_next;
            overflow_reg   <= overflow_reg | (ras_push & ras_full);
            underflow_reg  <= underflow_reg | underflow_set;
            case (state_reg)
                IDLE:    if (start) state_reg <= RUN;
                RUN:     if (halt_req || underflow_set) state_reg <= HALT;
                HALT:    state_reg <= HALT;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef PC_BRANCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            taken_count <= '0;
        else if (jump_taken_reg && (taken_count != 16'hFFFF))
            taken_count <= taken_count + 1'b1;
    end
`endif

    assign pc            = pc_reg;
    assign running       = (state_reg == RUN);
    assign jump_taken    = jump_taken_reg;
    assign ras_overflow  = overflow_reg;
    assign ras_underflow = underflow_reg;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: driver queues expected state, monitor compares after each edge.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        is_jump = 1'b0;
    logic        cond_met = 1'b0;
    logic        is_call = 1'b0;
    logic        is_ret = 1'b0;
    logic        halt_req = 1'b0;
    logic [15:0] jump_target = '0;
    logic [15:0] pc;
    logic        running;
    logic        jump_taken;
    logic        ras_overflow;
    logic        ras_underflow;
`ifdef PC_BRANCH_COUNT_EN
    logic [15:0] taken_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] pc;
        logic        jt;
        logic        run;
        logic        ovf;
        logic        unf;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    pc_branch_unit #(
        .ADDR_W      (16),
        .RESET_VECTOR(0),
        .RAS_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .step         (step),
        .is_jump      (is_jump),
        .cond_met     (cond_met),
        .is_call      (is_call),
        .is_ret       (is_ret),
        .halt_req     (halt_req),
        .jump_target  (jump_target),
        .pc           (pc),
`ifdef PC_BRANCH_COUNT_EN
        .taken_count  (taken_count),
`endif
        .running      (running),
        .jump_taken   (jump_taken),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: one expected record per clock edge that the driver issued.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn %-12s pc=0x%04h jt=%0d run=%0d ovf=%0d unf=%0d",
                     e.name, pc, jump_taken, running, ras_overflow, ras_underflow);
            chk({e.name, ".pc"},  32'(pc),            32'(e.pc));
            chk({e.name, ".jt"},  32'(jump_taken),    32'(e.jt));
            chk({e.name, ".run"}, 32'(running),       32'(e.run));
            chk({e.name, ".ovf"}, 32'(ras_overflow),  32'(e.ovf));
            chk({e.name, ".unf"}, 32'(ras_underflow), 32'(e.unf));
        end
    end

    task automatic cyc(input logic st, input logic stp, input logic jmp, input logic cm,
                       input logic cl, input logic rt, input logic hlt, input logic [15:0] tgt,
                       input logic [15:0] epc, input logic ejt, input logic erun,
                       input logic eovf, input logic eunf, input string nm);
        exp_t e;
        @(negedge clk);
        start       = st;
        step        = stp;
        is_jump     = jmp;
        cond_met    = cm;
        is_call     = cl;
        is_ret      = rt;
        halt_req    = hlt;
        jump_target = tgt;
        e.pc = epc; e.jt = ejt; e.run = erun; e.ovf = eovf; e.unf = eunf; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without waiting for an edge.
    task automatic do_reset(input string nm);
        @(negedge clk);
        {start, step, is_jump, cond_met, is_call, is_ret, halt_req} = '0;
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn %-12s pc=0x%04h jt=%0d run=%0d ovf=%0d unf=%0d",
                 nm, pc, jump_taken, running, ras_overflow, ras_underflow);
        chk({nm, ".pc"},  32'(pc),            32'h0);
        chk({nm, ".run"}, 32'(running),       32'h0);
        chk({nm, ".jt"},  32'(jump_taken),    32'h0);
        chk({nm, ".ovf"}, 32'(ras_overflow),  32'h0);
        chk({nm, ".unf"}, 32'(ras_underflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state, then start and three sequential steps
        cyc(0,0,0,0,0,0,0, 16'h0000, 16'h0000, 0,0,0,0, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1,0,0,0,0,0,0, 16'h0000, 16'h0000, 0,1,0,0, "start");
        cyc(0,1,0,0,0,0,0, 16'h0000, 16'h0001, 0,1,0,0, "seq1");
        cyc(0,1,0,0,0,0,0, 16'h0000, 16'h0002, 0,1,0,0, "seq2");
        cyc(0,1,0,0,0,0,0, 16'h0000, 16'h0003, 0,1,0,0, "seq3");
        // conditional jumps
        cyc(0,1,1,1,0,0,0, 16'h0040, 16'h0040, 1,1,0,0, "jmp_taken");
        cyc(0,1,1,0,0,0,0, 16'h0080, 16'h0041, 0,1,0,0, "jmp_nottkn");
        cyc(0,1,1,1,0,0,0, 16'h0010, 16'h0010, 1,1,0,0, "jmp_to_10");
        // call / return
        cyc(0,1,0,0,1,0,0, 16'h0100, 16'h0100, 1,1,0,0, "call");
        cyc(0,1,0,0,0,1,0, 16'h0000, 16'h0011, 1,1,0,0, "ret");
        cyc(0,0,0,0,0,0,0, 16'h0000, 16'h0011, 0,1,0,0, "no_step");
        // five nested calls into a 4-deep RAS
        cyc(0,1,0,0,1,0,0, 16'h0200, 16'h0200, 1,1,0,0, "call1");
        cyc(0,1,0,0,1,0,0, 16'h0300, 16'h0300, 1,1,0,0, "call2");
        cyc(0,1,0,0,1,0,0, 16'h0400, 16'h0400, 1,1,0,0, "call3");
        cyc(0,1,0,0,1,0,0, 16'h0500, 16'h0500, 1,1,0,0, "call4");
        cyc(0,1,0,0,1,0,0, 16'h0600, 16'h0600, 1,1,1,0, "call5_ovf");
        cyc(0,1,0,0,0,1,0, 16'h0000, 16'h0501, 1,1,1,0, "ret1");
        cyc(0,1,0,0,0,1,0, 16'h0000, 16'h0401, 1,1,1,0, "ret2");
        cyc(0,1,0,0,0,1,0, 16'h0000, 16'h0301, 1,1,1,0, "ret3");
        cyc(0,1,0,0,0,1,0, 16'h0000, 16'h0201, 1,1,1,0, "ret4");
        cyc(0,1,0,0,0,1,0, 16'h0000, 16'h0201, 0,0,1,1, "ret5_unf");
        cyc(0,1,0,0,0,0,0, 16'h0000, 16'h0201, 0,0,1,1, "halt_step");
        cyc(1,1,1,1,0,0,0, 16'h0077, 16'h0201, 0,0,1,1, "halt_start");
        // reset mid-RUN after two calls, RAS must be empty afterwards
        do_reset("rst_halt");
        cyc(1,0,0,0,0,0,0, 16'h0000, 16'h0000, 0,1,0,0, "start_b");
        cyc(0,1,0,0,1,0,0, 16'h0050, 16'h0050, 1,1,0,0, "callb1");
        cyc(0,1,0,0,1,0,0, 16'h0060, 16'h0060, 1,1,0,0, "callb2");
        do_reset("rst_run");
        cyc(1,0,0,0,0,0,0, 16'h0000, 16'h0000, 0,1,0,0, "start_c");
        cyc(0,1,0,0,0,1,0, 16'h0000, 16'h0000, 0,0,0,1, "ret_empty");
        // wrap and halt with step
        do_reset("rst_unf");
        cyc(1,0,0,0,0,0,0, 16'h0000, 16'h0000, 0,1,0,0, "start_d");
        cyc(0,1,1,1,0,0,0, 16'hFFFF, 16'hFFFF, 1,1,0,0, "jmp_ffff");
        cyc(0,1,0,0,0,0,0, 16'h0000, 16'h0000, 0,1,0,0, "wrap");
        cyc(0,1,0,0,0,0,1, 16'h0000, 16'h0001, 0,0,0,0, "step_halt");
        cyc(0,1,0,0,0,0,0, 16'h0000, 16'h0001, 0,0,0,0, "after_halt");
`ifdef PC_BRANCH_COUNT_EN
        do_reset("rst_cnt");
        cyc(1,0,0,0,0,0,0, 16'h0000, 16'h0000, 0,1,0,0, "start_e");
        cyc(0,1,1,1,0,0,0, 16'h0005, 16'h0005, 1,1,0,0, "cjmp1");
        cyc(0,1,1,1,0,0,0, 16'h0006, 16'h0006, 1,1,0,0, "cjmp2");
        cyc(0,1,1,1,0,0,0, 16'h0007, 16'h0007, 1,1,0,0, "cjmp3");
        cyc(0,0,0,0,0,0,0, 16'h0000, 16'h0007, 0,1,0,0, "cnt_idle");
        #1;
        chk("taken_count", 32'(taken_count), 32'd3);
`endif
        @(negedge clk);
        {start, step, is_jump, cond_met, is_call, is_ret, halt_req} = '0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
